// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-mem address, and loads the IF/ID register.
// Per-edge behaviour is chosen by priority: redirect, flush, stall, then normal fetch.
module instr_fetch_stage #(
    parameter int unsigned           ADDR_W    = 64,
    parameter int unsigned           INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = 32'hD503201F,
    parameter int unsigned           CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [CNT_W-1:0]   fetch_count
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        pc_d          = pc_q;
        valid_d       = valid_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        fetch_count_d = fetch_count_q;
        if (br_taken) begin
            // Targets are word aligned; the low two bits are dropped.
            pc_d       = br_target & ~ADDR_W'(3);
            valid_d    = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
        end else if (flush) begin
            if (!stall) begin
                pc_d = pc_plus4;
            end
            valid_d    = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            pc_d       = pc_plus4;
            valid_d    = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = imem_rdata;
            if (fetch_count_q != '1) begin
                fetch_count_d = fetch_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            id_pc_q       <= '0;
            id_instr_q    <= NOP_INSTR;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_instr = id_instr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; instruction memory returns the low 32 address bits.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] fetch_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr[31:0];

    instr_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst imem_addr got=%h exp=0", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst valid got=%b exp=0", if_id_valid); end
        total++; if (if_id_pc !== 64'h0) begin bad++; $display("FAIL rst if_id_pc got=%h exp=0", if_id_pc); end
        total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL rst instr got=%h exp=%h", if_id_instr, NOP); end
        total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst count got=%h exp=0", fetch_count); end
        reset = 1'b1;
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0) begin bad++; $display("FAIL seq first valid=%b pc=%h exp 1/0", if_id_valid, if_id_pc); end
        step();
        step();
        total++; if (if_id_pc !== 64'h8) begin bad++; $display("FAIL seq if_id_pc got=%h exp=8", if_id_pc); end
        total++; if (if_id_instr !== 32'h8) begin bad++; $display("FAIL seq instr got=%h exp=8", if_id_instr); end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL seq count got=%0d exp=3", fetch_count); end
        total++; if (imem_addr !== 64'hC) begin bad++; $display("FAIL seq imem_addr got=%h exp=c", imem_addr); end
    endtask

    task automatic test_stall();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (if_id_pc !== 64'hC || imem_addr !== 64'h10 || fetch_count !== 32'd4) begin
                bad++; $display("FAIL stall cyc%0d if_id_pc=%h imem=%h cnt=%0d exp c/10/4", i, if_id_pc, imem_addr, fetch_count);
            end
        end
        stall = 1'b0;
        step();
        total++; if (if_id_pc !== 64'h10 || if_id_instr !== 32'h10) begin bad++; $display("FAIL stall resume pc=%h instr=%h exp 10/10", if_id_pc, if_id_instr); end
        total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL stall resume count got=%0d exp=5", fetch_count); end
        step();
        total++; if (if_id_pc !== 64'h14 || fetch_count !== 32'd6) begin bad++; $display("FAIL stall next pc=%h cnt=%0d exp 14/6", if_id_pc, fetch_count); end
    endtask

    task automatic test_branch();
        step();
        step();
        total++; if (imem_addr !== 64'h20) begin bad++; $display("FAIL br setup imem_addr got=%h exp=20", imem_addr); end
        br_taken = 1'b1;
        br_target = 64'h103;
        step();
        br_taken = 1'b0;
        total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL br pc got=%h exp=100", imem_addr); end
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 64'h0) begin
            bad++; $display("FAIL br bubble valid=%b instr=%h pc=%h exp 0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP);
        end
        total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL br count got=%0d exp=8", fetch_count); end
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h100 || if_id_instr !== 32'h100) begin
            bad++; $display("FAIL br target valid=%b pc=%h instr=%h exp 1/100/100", if_id_valid, if_id_pc, if_id_instr);
        end
        total++; if (fetch_count !== 32'd9 || imem_addr !== 64'h104) begin bad++; $display("FAIL br after cnt=%0d imem=%h exp 9/104", fetch_count, imem_addr); end
    endtask

    task automatic test_priority();
        stall = 1'b1;
        flush = 1'b1;
        step();
        total++; if (imem_addr !== 64'h104 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            bad++; $display("FAIL prio stall+flush imem=%h valid=%b instr=%h exp 104/0/nop", imem_addr, if_id_valid, if_id_instr);
        end
        stall = 1'b0;
        step();
        flush = 1'b0;
        total++; if (imem_addr !== 64'h108 || if_id_valid !== 1'b0 || fetch_count !== 32'd9) begin
            bad++; $display("FAIL prio flush imem=%h valid=%b cnt=%0d exp 108/0/9", imem_addr, if_id_valid, fetch_count);
        end
        step();
        total++; if (if_id_pc !== 64'h108 || fetch_count !== 32'd10) begin bad++; $display("FAIL prio refetch pc=%h cnt=%0d exp 108/10", if_id_pc, fetch_count); end
        br_taken = 1'b1;
        stall = 1'b1;
        br_target = 64'h200;
        step();
        br_taken = 1'b0;
        stall = 1'b0;
        total++; if (imem_addr !== 64'h200 || if_id_valid !== 1'b0) begin bad++; $display("FAIL prio br+stall imem=%h valid=%b exp 200/0", imem_addr, if_id_valid); end
        step();
        total++; if (if_id_pc !== 64'h200 || fetch_count !== 32'd11) begin bad++; $display("FAIL prio br target pc=%h cnt=%0d exp 200/11", if_id_pc, fetch_count); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        br_taken = 1'b0;
        total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap setup imem=%h exp fffffffffffffffc", imem_addr); end
        step();
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL wrap pc got=%h exp=0", imem_addr); end
        total++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_instr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap capture pc=%h instr=%h", if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_saturation();
        force dut.fetch_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.fetch_count_q;
        #1;
        total++; if (fetch_count !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sat preload got=%h exp=fffffffd", fetch_count); end
        step();
        total++; if (fetch_count !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat +1 got=%h exp=fffffffe", fetch_count); end
        step();
        total++; if (fetch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat top got=%h exp=ffffffff", fetch_count); end
        step();
        step();
        total++; if (fetch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat stick got=%h exp=ffffffff", fetch_count); end
    endtask

    task automatic test_reset_mid();
        br_taken = 1'b1;
        br_target = 64'h300;
        #2;
        reset = 1'b0;
        #1;
        total++; if (imem_addr !== 64'h0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0) begin
            bad++; $display("FAIL midrst async imem=%h valid=%b pc=%h exp 0/0/0", imem_addr, if_id_valid, if_id_pc);
        end
        total++; if (if_id_instr !== NOP || fetch_count !== 32'h0) begin bad++; $display("FAIL midrst async instr=%h cnt=%h", if_id_instr, fetch_count); end
        step();
        br_taken = 1'b0;
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL midrst hold imem=%h exp=0", imem_addr); end
        reset = 1'b1;
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || imem_addr !== 64'h4 || fetch_count !== 32'd1) begin
            bad++; $display("FAIL midrst restart valid=%b pc=%h imem=%h cnt=%0d exp 1/0/4/1", if_id_valid, if_id_pc, imem_addr, fetch_count);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_priority();
        test_wrap();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
